// File: rtl/spi_slave_param_if.sv
// ---------------------------------------------------------------------------
// spi_slave_param_if
// User-side bus of the SPI slave: the received-word strobe and the transmit
// holding-buffer handshake.
//
// Signals:
//   si_data   slave -> user  last complete received word
//   si_done   slave -> user  one-cycle pulse when si_data updates
//   so_data   user -> slave  word to transmit
//   so_start  user -> slave  valid: offer so_data to the holding buffer
//   so_ready  slave -> user  ready: holding buffer empty
//
// Handshake: so_start is the valid and so_ready the ready of a valid/ready
// pair. so_data is transferred on a rising clk edge where
// so_start && so_ready; so_start while so_ready is low is dropped (not held
// over). so_ready is registered and depends only on the buffer state.
//
// Modports: slave (the SPI block), master (the user logic).
// ---------------------------------------------------------------------------
interface spi_slave_param_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] si_data;
  logic                  si_done;
  logic [DATA_WIDTH-1:0] so_data;
  logic                  so_start;
  logic                  so_ready;

  modport slave (
    output si_data, si_done, so_ready,
    input  so_data, so_start
  );

  modport master (
    input  si_data, si_done, so_ready,
    output so_data, so_start
  );
endinterface

// File: rtl/spi_slave_param.sv
// ---------------------------------------------------------------------------
// spi_slave_param
// Parametrised SPI slave in the clk domain: any word width, all four
// CPOL/CPHA modes (latched per transaction), multi-word bursts within one
// chip-select assertion and a one-word TX holding buffer.
//
// Parameters: DATA_WIDTH (>= 4), SYNC_STAGES (>= 2), MSB_FIRST (1/0).
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   sclk, mosi, cs  SPI pins from the master (asynchronous, cs active low)
//   miso            serial data out, 'z' while cs is high
//   cpol, cpha      SPI mode, latched when synchronised cs falls
//   so_underrun     sticky underrun flag (only with SPI_SLAVE_UNDERRUN_FLAG_EN)
//   dbg_state       {tx_active, rx_active} FSM state for observation
//   user            spi_slave_param_if.slave (si_*/so_* user bus)
//
// Optional feature macro: SPI_SLAVE_UNDERRUN_FLAG_EN adds so_underrun.
// ---------------------------------------------------------------------------
module spi_slave_param #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic mosi,
  output logic miso,
  input  logic cs,
  input  logic cpol,
  input  logic cpha,
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
  output logic so_underrun,
`endif
  output logic [1:0] dbg_state,
  spi_slave_param_if.slave user
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {RX_IDLE, RX_ACTIVE} rx_state_e;
  typedef enum logic {TX_IDLE, TX_ACTIVE} tx_state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic sclk_prev_q, sclk_prev_d;
  logic cs_prev_q, cs_prev_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d;

  rx_state_e rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] si_data_q, si_data_d;
  logic si_done_q, si_done_d;

  tx_state_e tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic buf_full_q, buf_full_d;
  logic tx_load;

  logic sclk_s, mosi_s, cs_s, cs_fall;
  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, drive_edge;
  logic [DATA_WIDTH-1:0] rx_next;

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign cs_fall = cs_prev_q & ~cs_s;

  // Edge roles come from the mode latched at cs fall, never the live pins.
  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign drive_edge  = cpha_q ? lead_edge : trail_edge;

  assign rx_next = MSB_FIRST ? {rx_shift_q[DATA_WIDTH-2:0], mosi_s}
                             : {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    if (cs_fall) begin
      cpol_d = cpol;
      cpha_d = cpha;
    end

    // RX path
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_shift_d = rx_shift_q;
    si_data_d  = si_data_q;
    si_done_d  = 1'b0;
    if (cs_s) begin
      // Partial word is dropped; nothing is reported.
      rx_state_d = RX_IDLE;
      rx_cnt_d   = '0;
      rx_shift_d = '0;
    end else begin
      case (rx_state_q)
        RX_IDLE:   rx_state_d = RX_ACTIVE;
        RX_ACTIVE: begin
          if (sample_edge) begin
            rx_shift_d = rx_next;
            if (rx_cnt_q == CNT_LAST) begin
              rx_cnt_d  = '0;
              si_data_d = rx_next;
              si_done_d = 1'b1;
            end else begin
              rx_cnt_d = rx_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end

    // TX path
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    tx_load    = 1'b0;
    if (cs_s) begin
      tx_state_d = TX_IDLE;
      tx_cnt_d   = '0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_state_d = TX_ACTIVE;
          // CPHA=0 needs the first bit on miso before the first edge; the
          // mode is being latched this very cycle, so use the live pin.
          tx_load = cs_fall & ~cpha;
        end
        TX_ACTIVE: begin
          if (drive_edge) begin
            tx_cnt_d = (tx_cnt_q == CNT_LAST) ? '0 : tx_cnt_q + 1'b1;
            if (cpha_q ? (tx_cnt_q == '0) : (tx_cnt_q == CNT_LAST)) begin
              tx_load = 1'b1;
            end else begin
              tx_shift_d = MSB_FIRST ? {tx_shift_q[DATA_WIDTH-2:0], 1'b0}
                                     : {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
            end
          end
        end
      endcase
    end

    if (tx_load) begin
      // Empty buffer: a same-cycle so_start bypasses it, otherwise zeros.
      if (buf_full_q)         tx_shift_d = buf_q;
      else if (user.so_start) tx_shift_d = user.so_data;
      else                    tx_shift_d = '0;
      buf_full_d = 1'b0;
    end else if (user.so_start && !buf_full_q) begin
      buf_d      = user.so_data;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_shift_q  <= '0;
      si_data_q   <= '0;
      si_done_q   <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_shift_q  <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_shift_q  <= rx_shift_d;
      si_data_q   <= si_data_d;
      si_done_q   <= si_done_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_shift_q  <= tx_shift_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
  logic underrun_q, underrun_d;

  // Clear on cs fall, but an underrun load in the same cycle wins.
  always_comb begin
    underrun_d = underrun_q;
    if (cs_fall) underrun_d = 1'b0;
    if (tx_load && !buf_full_q && !user.so_start) underrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) underrun_q <= 1'b0;
    else       underrun_q <= underrun_d;
  end

  assign so_underrun = underrun_q;
`endif

  // Tristate follows the raw pin so the bus is released immediately.
  assign miso = cs ? 1'bz : (MSB_FIRST ? tx_shift_q[DATA_WIDTH-1] : tx_shift_q[0]);

  assign user.si_data  = si_data_q;
  assign user.si_done  = si_done_q;
  assign user.so_ready = ~buf_full_q;
  assign dbg_state     = {tx_state_q == TX_ACTIVE, rx_state_q == RX_ACTIVE};

endmodule

// File: tb/tb_spi_slave_param.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_param
// Directed bench for spi_slave_param. Two instances share sclk/mosi/mode
// pins and have their own chip selects:
//   u_a : DATA_WIDTH=8,  MSB first
//   u_b : DATA_WIDTH=12, LSB first
// ---------------------------------------------------------------------------
module tb_spi_slave_param;

  localparam int HALF = 6;  // clk cycles per sclk phase

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic sclk, mosi, cs_a, cs_b, cpol, cpha;
  wire  miso_a, miso_b;
  logic [1:0] dbg_a, dbg_b;
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
  logic und_a, und_b;
`endif

  spi_slave_param_if #(.DATA_WIDTH(8))  ifa ();
  spi_slave_param_if #(.DATA_WIDTH(12)) ifb ();

  spi_slave_param #(.DATA_WIDTH(8), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .miso(miso_a),
    .cs(cs_a), .cpol(cpol), .cpha(cpha),
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
    .so_underrun(und_a),
`endif
    .dbg_state(dbg_a), .user(ifa)
  );

  spi_slave_param #(.DATA_WIDTH(12), .SYNC_STAGES(2), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .miso(miso_b),
    .cs(cs_b), .cpol(cpol), .cpha(cpha),
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
    .so_underrun(und_b),
`endif
    .dbg_state(dbg_b), .user(ifb)
  );

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_a_q[$];
  logic [15:0] got_b_q[$];
  logic [15:0] m_tx[4];
  logic [15:0] m_rx[4];

  always @(negedge clk) begin
    if (ifa.si_done) got_a_q.push_back(16'(ifa.si_data));
    if (ifb.si_done) got_b_q.push_back(16'(ifb.si_data));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare received words of one instance against exp_q, then clear both.
  task automatic check_rx(input int sel, input string tag);
    int n;
    n = (sel == 0) ? got_a_q.size() : got_b_q.size();
    check({tag, "_count"}, 32'(n), 32'(exp_q.size()));
    for (int k = 0; k < n && k < exp_q.size(); k++)
      check(tag, 32'((sel == 0) ? got_a_q[k] : got_b_q[k]), 32'(exp_q[k]));
    exp_q.delete();
    got_a_q.delete();
    got_b_q.delete();
  endtask

  // driver tasks
  task automatic push_word(input int sel, input logic [15:0] data);
    int i;
    for (i = 0; i < 2000; i++) begin
      if (((sel == 0) ? ifa.so_ready : ifb.so_ready) === 1'b1) break;
      @(negedge clk);
    end
    if (i == 2000) begin
      checks++;
      errors++;
      $error("FAIL so_ready_timeout observed=0 expected=1");
    end
    if (sel == 0) begin ifa.so_data = data[7:0];  ifa.so_start = 1'b1; end
    else          begin ifb.so_data = data[11:0]; ifb.so_start = 1'b1; end
    @(negedge clk);
    ifa.so_start = 1'b0;
    ifb.so_start = 1'b0;
  endtask

  task automatic spi_xfer(input int sel, input bit pol, input bit pha,
                          input int width, input bit lsb, input int nbits);
    int w, b, idx;
    for (int k = 0; k < 4; k++) m_rx[k] = '0;
    cpol = pol;
    cpha = pha;
    sclk = pol;
    mosi = 1'b0;
    repeat (HALF) @(negedge clk);
    if (sel == 0) cs_a = 1'b0; else cs_b = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      w   = i / width;
      b   = i % width;
      idx = lsb ? b : width - 1 - b;
      if (!pha) begin
        mosi = m_tx[w][idx];
        repeat (HALF) @(negedge clk);
        m_rx[w][idx] = (sel == 0) ? miso_a : miso_b;
        sclk = ~sclk;
        repeat (HALF) @(negedge clk);
        sclk = ~sclk;
      end else begin
        repeat (HALF) @(negedge clk);
        sclk = ~sclk;
        mosi = m_tx[w][idx];
        repeat (HALF) @(negedge clk);
        m_rx[w][idx] = (sel == 0) ? miso_a : miso_b;
        sclk = ~sclk;
      end
    end
    repeat (HALF) @(negedge clk);
    cs_a = 1'b1;
    cs_b = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    sclk = 1'b0; mosi = 1'b0; cs_a = 1'b1; cs_b = 1'b1; cpol = 1'b0; cpha = 1'b0;
    ifa.so_data = '0; ifa.so_start = 1'b0;
    ifb.so_data = '0; ifb.so_start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_si_data", 32'(ifa.si_data), 32'h0);
    check("rst_si_done", 32'(ifa.si_done), 32'h0);
    check("rst_so_ready", 32'(ifa.so_ready), 32'h1);
    check("rst_dbg", 32'(dbg_a), 32'h0);
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
    check("rst_underrun", 32'(und_a), 32'h0);
`endif

    // mode 0: send A5, preloaded 3C; a so_start while full is ignored
    push_word(0, 16'h3C);
    check("m0_ready_after_load", 32'(ifa.so_ready), 32'h0);
    ifa.so_data = 8'h44; ifa.so_start = 1'b1;
    @(negedge clk);
    ifa.so_start = 1'b0;
    @(negedge clk);
    check("m0_ready_ignored_start", 32'(ifa.so_ready), 32'h0);
    m_tx[0] = 16'hA5;
    exp_q.push_back(16'hA5);
    spi_xfer(0, 1'b0, 1'b0, 8, 1'b0, 8);
    check_rx(0, "m0_rx");
    check("m0_miso", 32'(m_rx[0]), 32'h3C);
    check("m0_ready_after", 32'(ifa.so_ready), 32'h1);

    // mode 3 burst of three words, refilled on so_ready
    push_word(0, 16'hC1);
    m_tx[0] = 16'h11; m_tx[1] = 16'h22; m_tx[2] = 16'h33;
    exp_q.push_back(16'h11); exp_q.push_back(16'h22); exp_q.push_back(16'h33);
    fork
      spi_xfer(0, 1'b1, 1'b1, 8, 1'b0, 24);
      begin
        push_word(0, 16'hC2);
        push_word(0, 16'hC3);
      end
    join
    check_rx(0, "m3_rx");
    check("m3_miso0", 32'(m_rx[0]), 32'hC1);
    check("m3_miso1", 32'(m_rx[1]), 32'hC2);
    check("m3_miso2", 32'(m_rx[2]), 32'hC3);

    // 12-bit LSB-first instance, mode 1
    push_word(1, 16'h5E3);
    m_tx[0] = 16'hABC;
    exp_q.push_back(16'hABC);
    spi_xfer(1, 1'b0, 1'b1, 12, 1'b1, 12);
    check_rx(1, "w12_rx");
    check("w12_si_data", 32'(ifb.si_data), 32'hABC);
    check("w12_miso", 32'(m_rx[0]), 32'h5E3);

    // cs aborted after 5 bits: no si_done, buffer contents kept
    push_word(0, 16'h81);
    m_tx[0] = 16'hFF;
    fork
      spi_xfer(0, 1'b0, 1'b0, 8, 1'b0, 5);
      push_word(0, 16'h6B);
    join
    check_rx(0, "abort_rx");
    check("abort_ready_kept", 32'(ifa.so_ready), 32'h0);
    m_tx[0] = 16'h5A;
    exp_q.push_back(16'h5A);
    spi_xfer(0, 1'b0, 1'b0, 8, 1'b0, 8);
    check_rx(0, "after_abort_rx");
    check("after_abort_miso", 32'(m_rx[0]), 32'h6B);

    // underrun on the second word of a mode 0 burst
    push_word(0, 16'h77);
    m_tx[0] = 16'h12; m_tx[1] = 16'h34;
    exp_q.push_back(16'h12); exp_q.push_back(16'h34);
    spi_xfer(0, 1'b0, 1'b0, 8, 1'b0, 16);
    check_rx(0, "ur_rx");
    check("ur_miso0", 32'(m_rx[0]), 32'h77);
    check("ur_miso1", 32'(m_rx[1]), 32'h00);
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
    check("ur_flag_set", 32'(und_a), 32'h1);
`endif
    // mode 1 with a full buffer: flag clears at cs fall and stays clear
    push_word(0, 16'h0F);
    m_tx[0] = 16'hF0;
    exp_q.push_back(16'hF0);
    spi_xfer(0, 1'b0, 1'b1, 8, 1'b0, 8);
    check_rx(0, "m1_rx");
    check("m1_miso", 32'(m_rx[0]), 32'h0F);
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
    check("ur_flag_cleared", 32'(und_a), 32'h0);
`endif

    // reset in the middle of a word
    cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
    cs_a = 1'b0;
    repeat (HALF) @(negedge clk);
    push_word(0, 16'h55);
    check("mid_ready_before_rst", 32'(ifa.so_ready), 32'h0);
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
    check("mid_flag_before_rst", 32'(und_a), 32'h1);
`endif
    mosi = 1'b1; sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
    repeat (HALF) @(negedge clk);
    sclk = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_si_data_a", 32'(ifa.si_data), 32'h0);
    check("mid_rst_si_data_b", 32'(ifb.si_data), 32'h0);
    check("mid_rst_si_done", 32'(ifa.si_done), 32'h0);
    check("mid_rst_so_ready", 32'(ifa.so_ready), 32'h1);
    check("mid_rst_miso", 32'(miso_a), 32'h0);
    check("mid_rst_dbg", 32'(dbg_a), 32'h0);
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
    check("mid_rst_flag", 32'(und_a), 32'h0);
`endif
    cs_a = 1'b1; sclk = 1'b0;
    repeat (4 * HALF) @(negedge clk);
    check_rx(0, "mid_rst_no_word");
    m_tx[0] = 16'h96;
    exp_q.push_back(16'h96);
    spi_xfer(0, 1'b0, 1'b0, 8, 1'b0, 8);
    check_rx(0, "post_rst_rx");
    check("post_rst_miso", 32'(m_rx[0]), 32'h00);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
